// File: rtl/vga_grid_renderer.sv
// Draws the 8x8 battleship board over the VGA raster: snapshots the ship maps once per frame,
// then maps each pixel to a cell colour through a two-stage pipeline with syncs kept aligned.
module vga_grid_renderer #(
  parameter int GRID_X0   = 192,
  parameter int GRID_Y0   = 112,
  parameter int CELL_LOG2 = 5
) (
  input  logic        clk,
  input  logic        resetGeral,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_start,
  input  logic        exibeMapa,
  input  logic        jogadorVGA,
  input  logic [63:0] dataEmbarcacaoSubmarinoUm,
  input  logic [63:0] dataEmbarcacaoSubmarinoDois,
  input  logic [63:0] dataEmbarcacaoSubmarinoTres,
  input  logic [63:0] dataEmbarcacaoSubmarinoQuatro,
  input  logic [63:0] dataEmbarcacaoSubmarinoCinco,
  input  logic [63:0] dataEmbarcacaoCruzadorUm,
  input  logic [63:0] dataEmbarcacaoCruzadorDois,
  input  logic [63:0] dataEmbarcacaoHidroaviaoUm,
  input  logic [63:0] dataEmbarcacaoHidroaviaoDois,
  input  logic [63:0] dataEmbarcacaoEncouracado,
  input  logic [63:0] dataEmbarcacaoPortaAvioes,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out
);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  localparam logic signed [10:0] L_ZERO  = 11'sd0;
  localparam logic signed [10:0] L_BOARD = 11'(8 << CELL_LOG2);
  localparam logic signed [10:0] L_BLO   = -11'sd2;
  localparam logic signed [10:0] L_BHI   = L_BOARD + 11'sd1;

  // Map index order: 0-4 submarines, 5-6 cruisers, 7-8 seaplanes, 9 battleship, 10 carrier.
  logic [10:0][63:0] w_maps;
  assign w_maps = {dataEmbarcacaoPortaAvioes, dataEmbarcacaoEncouracado,
                   dataEmbarcacaoHidroaviaoDois, dataEmbarcacaoHidroaviaoUm,
                   dataEmbarcacaoCruzadorDois, dataEmbarcacaoCruzadorUm,
                   dataEmbarcacaoSubmarinoCinco, dataEmbarcacaoSubmarinoQuatro,
                   dataEmbarcacaoSubmarinoTres, dataEmbarcacaoSubmarinoDois,
                   dataEmbarcacaoSubmarinoUm};

  state_t            r_state;
  logic [10:0][63:0] r_maps;
  logic              r_player;
  logic              r_show_req;

  // NOTE: sequential state uses non-blocking assignments and the async reset
  // clears every register, snapshot included, so a reset mid-frame blanks at once.
  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      r_state    <= ST_BLANK;
      r_maps     <= '0;
      r_player   <= 1'b0;
      r_show_req <= 1'b0;
    end else if (frame_start) begin
      r_maps     <= w_maps;
      r_player   <= jogadorVGA;
      r_show_req <= exibeMapa;
      case (r_state)
        ST_BLANK: if (exibeMapa)  r_state <= ST_SHOW;
        ST_SHOW:  if (!exibeMapa) r_state <= ST_BLANK;
        default:  r_state <= ST_BLANK;
      endcase
    end
  end

  logic signed [10:0] w_dx, w_dy;
  logic               w_in_grid, w_in_box, w_is_line;
  assign w_dx      = signed'({1'b0, pixel_x}) - 11'(GRID_X0);
  assign w_dy      = signed'({1'b0, pixel_y}) - 11'(GRID_Y0);
  assign w_in_grid = (w_dx >= L_ZERO) && (w_dx < L_BOARD) && (w_dy >= L_ZERO) && (w_dy < L_BOARD);
  assign w_in_box  = (w_dx >= L_BLO) && (w_dx <= L_BHI) && (w_dy >= L_BLO) && (w_dy <= L_BHI);
  assign w_is_line = w_in_grid && ((w_dx[CELL_LOG2-1:0] == '0) || (w_dy[CELL_LOG2-1:0] == '0));

  logic       r_s1_von, r_s1_hs, r_s1_vs, r_s1_in_grid, r_s1_in_border, r_s1_line;
  logic [5:0] r_s1_cell;

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      r_s1_von       <= 1'b0;
      r_s1_hs        <= 1'b1;
      r_s1_vs        <= 1'b1;
      r_s1_in_grid   <= 1'b0;
      r_s1_in_border <= 1'b0;
      r_s1_line      <= 1'b0;
      r_s1_cell      <= '0;
    end else begin
      r_s1_von       <= video_on;
      r_s1_hs        <= hsync_in;
      r_s1_vs        <= vsync_in;
      r_s1_in_grid   <= w_in_grid;
      r_s1_in_border <= w_in_box && !w_in_grid;
      r_s1_line      <= w_is_line;
      r_s1_cell      <= {w_dy[CELL_LOG2+2:CELL_LOG2], w_dx[CELL_LOG2+2:CELL_LOG2]};
    end
  end

  logic [10:0] w_hit;
  logic [11:0] w_rgb;
  always_comb begin
    for (int i = 0; i < 11; i++) w_hit[i] = r_maps[i][r_s1_cell];
  end

  // NOTE: w_rgb gets a default before the priority chain so no path infers a latch.
  always_comb begin
    w_rgb = 12'h008;
    if (!r_s1_von || r_state == ST_BLANK) w_rgb = 12'h000;
    else if (r_s1_in_border)              w_rgb = r_player ? 12'hF00 : 12'h00F;
    else if (!r_s1_in_grid)               w_rgb = 12'h000;
    else if (r_s1_line)                   w_rgb = 12'hFFF;
    else if (w_hit[10])                   w_rgb = 12'hF80;
    else if (w_hit[9])                    w_rgb = 12'h888;
    else if (|w_hit[8:7])                 w_rgb = 12'h0F0;
    else if (|w_hit[6:5])                 w_rgb = 12'hFF0;
    else if (|w_hit[4:0])                 w_rgb = 12'h0FF;
  end

  logic [11:0] r_rgb;
  logic        r_hs, r_vs;
  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign {vga_r, vga_g, vga_b} = r_rgb;
  assign hsync_out = r_hs;
  assign vsync_out = r_vs;

  logic w_unused;
  assign w_unused = r_show_req;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Scoreboard bench for vga_grid_renderer: pixel stimulus pushes expected {rgb,hsync,vsync}
// into a queue; a monitor pops and compares two clocks after each issued pixel.
module tb_vga_grid_renderer;

  logic        clk = 1'b0;
  logic        resetGeral;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in, frame_start, exibeMapa, jogadorVGA;
  logic [63:0] sub1, sub2, sub3, sub4, sub5, cruz1, cruz2, hid1, hid2, enc, pa;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out;

  always #5 clk = ~clk;

  vga_grid_renderer dut (
    .clk(clk), .resetGeral(resetGeral),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .exibeMapa(exibeMapa), .jogadorVGA(jogadorVGA),
    .dataEmbarcacaoSubmarinoUm(sub1), .dataEmbarcacaoSubmarinoDois(sub2),
    .dataEmbarcacaoSubmarinoTres(sub3), .dataEmbarcacaoSubmarinoQuatro(sub4),
    .dataEmbarcacaoSubmarinoCinco(sub5), .dataEmbarcacaoCruzadorUm(cruz1),
    .dataEmbarcacaoCruzadorDois(cruz2), .dataEmbarcacaoHidroaviaoUm(hid1),
    .dataEmbarcacaoHidroaviaoDois(hid2), .dataEmbarcacaoEncouracado(enc),
    .dataEmbarcacaoPortaAvioes(pa),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  typedef struct {
    logic [13:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  logic  issue = 1'b0;
  logic [1:0] pipe = 2'b00;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rgb=%03h hs=%b vs=%b, want rgb=%03h hs=%b vs=%b",
               name, act[13:2], act[1], act[0], exp[13:2], exp[1], exp[0]);
    end
  endtask

  // Tracks which clock slots carry a scored pixel.
  initial forever begin
    @(posedge clk);
    pipe = {pipe[0], issue};
  end

  initial forever begin
    @(negedge clk);
    if (pipe[1]) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output slot with empty queue");
      end else begin
        item_t it;
        it = q.pop_front();
        check(it.name, {vga_r, vga_g, vga_b, hsync_out, vsync_out}, it.exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      issue = 1'b0;
    end
  endtask

  task automatic px(input int x, input int y, input logic von, input logic hs, input logic vs,
                    input logic [11:0] rgb, input string name);
    item_t it;
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    issue    = 1'b1;
    it.exp   = {rgb, hs, vs};
    it.name  = name;
    q.push_back(it);
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] rgb, input string name);
    px(x, y, 1'b1, 1'b1, 1'b1, rgb, name);
  endtask

  task automatic frame();
    idle(3);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    resetGeral = 1'b0;
    {pixel_x, pixel_y} = '0;
    {video_on, frame_start, exibeMapa, jogadorVGA} = '0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    {sub1, sub2, sub3, sub4, sub5, cruz1, cruz2, hid1, hid2, enc, pa} = '0;
    #12;
    check("reset_state", {vga_r, vga_g, vga_b, hsync_out, vsync_out}, {12'h000, 1'b1, 1'b1});
    resetGeral = 1'b1;

    // Board hidden; syncs still track with 2-clock delay.
    frame();
    px(200, 120, 1'b1, 1'b0, 1'b0, 12'h000, "hidden_syncs_low");

    exibeMapa = 1'b1; pa = 64'h1;
    frame();
    pix(197, 117, 12'hF80, "pa_cell0");
    pix(229, 117, 12'h008, "water_cell1");
    px(197, 117, 1'b0, 1'b1, 1'b1, 12'h000, "video_off");

    sub1 = 64'h8000_0000_0000_0000; pa = 64'h8000_0000_0000_0000;
    frame();
    pix(421, 341, 12'hF80, "pa_over_sub_cell63");
    pix(197, 117, 12'h008, "cell0_water");
    pa = '0;
    frame();
    pix(421, 341, 12'h0FF, "sub_cell63");

    cruz1 = '1;
    idle(2);
    pix(197, 117, 12'h008, "no_snapshot_midframe");
    frame();
    pix(197, 117, 12'hFF0, "cruz_cell0");
    pix(421, 341, 12'hFF0, "cruz_over_sub");

    enc = 64'h2; hid2 = 64'h4;
    frame();
    pix(229, 117, 12'h888, "enc_cell1");
    pix(261, 117, 12'h0F0, "hid_cell2");
    pix(224, 130, 12'hFFF, "grid_line");
    pix(192, 117, 12'hFFF, "grid_left_edge_line");
    pix(197, 367, 12'hFF0, "last_row_dy255");
    pix(197, 368, 12'h00F, "border_dy256");
    pix(197, 370, 12'h000, "outside_dy258");
    pix(447, 117, 12'hFF0, "last_col_dx255");
    pix(448, 117, 12'h00F, "border_dx256");
    pix(191, 112, 12'h00F, "border_p0");
    pix(190, 110, 12'h00F, "border_corner");
    pix(189, 112, 12'h000, "outside_dx_m3");

    jogadorVGA = 1'b1;
    frame();
    pix(191, 112, 12'hF00, "border_p1");

    // Hold a non-black pixel with syncs low, then reset between edges.
    idle(3);
    pixel_x = 10'd197; pixel_y = 10'd117; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    idle(3);
    #2;
    resetGeral = 1'b0;
    #1;
    check("async_reset", {vga_r, vga_g, vga_b, hsync_out, vsync_out}, {12'h000, 1'b1, 1'b1});
    idle(2);
    resetGeral = 1'b1;
    pix(197, 117, 12'h000, "blank_after_reset");
    exibeMapa = 1'b0;
    frame();
    pix(197, 117, 12'h000, "blank_exibe0");
    exibeMapa = 1'b1;
    frame();
    pix(191, 112, 12'hF00, "show_again_p1");
    pix(197, 117, 12'hFF0, "show_again_cruz");

    idle(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d items left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
